// File: rtl/derand_pkg.sv
`default_nettype none
// ============================================================================
// Module   : derand_pkg
// Brief    : Shared FSM encoding and PRBS (1 + x^14 + x^15) step helper.
// Revision : 1.0 - initial release
// ============================================================================
package derand_pkg;

    localparam int PRBS_W      = 15;
    localparam int PRBS_TAP_HI = 14;
    localparam int PRBS_TAP_LO = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [PRBS_W-1:0] vect;
        logic              key;
    } prbs_step_t;

    // One keystream bit: feedback from the two taps, shifted in at bit 0.
    function automatic prbs_step_t prbs_step(input logic [PRBS_W-1:0] vect);
        prbs_step_t step;
        step.key  = vect[PRBS_TAP_HI] ^ vect[PRBS_TAP_LO];
        step.vect = {vect[PRBS_W-2:0], step.key};
        return step;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs15_par.sv
`default_nettype none
// ============================================================================
// Module   : prbs15_par
// Brief    : W-step unrolled PRBS15 scrambler/descrambler (combinational).
// Revision : 1.0 - initial release
// ============================================================================
module prbs15_par
    import derand_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [PRBS_W-1:0] i_vect,
    input  logic [W-1:0]      i_data,
    output logic [W-1:0]      o_data,
    output logic [PRBS_W-1:0] o_vect
);

    logic [PRBS_W-1:0] w_chain [0:W];
    logic [W-1:0]      w_key;

    assign w_chain[0] = i_vect;

    // Bit 0 is earliest in time, so it consumes the first step of the chain.
    for (genvar i = 0; i < W; i++) begin : g_step
        prbs_step_t w_step;
        assign w_step         = prbs_step(w_chain[i]);
        assign w_chain[i + 1] = w_step.vect;
        assign w_key[i]       = w_step.key;
    end

    assign o_data = i_data ^ w_key;
    assign o_vect = w_chain[W];

endmodule
`default_nettype wire

// File: rtl/derand_burst.sv
`default_nettype none
// ============================================================================
// Module   : derand_burst
// Brief    : Per-burst PRBS15 derandomizer with payload count and pad drop.
// Revision : 1.0 - initial release
// ============================================================================
module derand_burst
    import derand_pkg::*;
#(
    parameter int W     = 8,
    parameter int LEN_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              burst_start,
    input  logic [14:0]       rand_iv,
    input  logic [LEN_W-1:0]  data_words,
    input  logic [LEN_W-1:0]  pad_words,
    input  logic [W-1:0]      in_bits,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [W-1:0]      out_bits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              burst_done,
    output logic              start_err
);

    state_t             r_state;
    logic [PRBS_W-1:0]  r_vect;
    logic [LEN_W-1:0]   r_dcnt;
    logic [LEN_W-1:0]   r_pcnt;
    logic [W-1:0]       r_out_bits;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_done;
    logic               r_start_err;

    state_t             w_state_nxt;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_load;
    logic               w_done_nxt;
    logic [W-1:0]       w_descr;
    logic [PRBS_W-1:0]  w_vect_nxt;

    prbs15_par #(
        .W (W)
    ) u_prbs (
        .i_vect (r_vect),
        .i_data (in_bits),
        .o_data (w_descr),
        .o_vect (w_vect_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (burst_start) begin
                    w_load = 1'b1;
                    if (data_words != '0) begin
                        w_state_nxt = ST_DATA;
                    end else if (pad_words != '0) begin
                        w_state_nxt = ST_PAD;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                // Single output register: accept only if it is free or draining now.
                w_in_ready = !r_out_valid || out_ready;
                if (in_valid && w_in_ready && (r_dcnt == LEN_W'(1))) begin
                    if (r_pcnt != '0) begin
                        w_state_nxt = ST_PAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                w_in_ready = 1'b1;
                if (in_valid && (r_pcnt == LEN_W'(1))) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid && w_in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vect      <= '0;
            r_dcnt      <= '0;
            r_pcnt      <= '0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_done      <= w_done_nxt;
            r_start_err <= burst_start && (r_state != ST_IDLE);
            if (w_load) begin
                r_vect <= rand_iv;
                r_dcnt <= data_words;
                r_pcnt <= pad_words;
            end else if (w_accept) begin
                // Pad words still advance the keystream.
                r_vect <= w_vect_nxt;
                if (r_state == ST_DATA) begin
                    r_dcnt <= r_dcnt - LEN_W'(1);
                end else begin
                    r_pcnt <= r_pcnt - LEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_bits  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept && (r_state == ST_DATA)) begin
            r_out_bits  <= w_descr;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_dcnt == LEN_W'(1));
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_bits   = r_out_bits;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign burst_done = r_done;
    assign start_err  = r_start_err;

endmodule
`default_nettype wire

// File: tb/tb_derand_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_derand_burst
// Brief    : Directed self-checking bench with a keystream-recurrence model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_derand_burst;

    localparam int W     = 8;
    localparam int LEN_W = 11;
    localparam int MAXW  = 80;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             burst_start = 1'b0;
    logic [14:0]      rand_iv = '0;
    logic [LEN_W-1:0] data_words = '0;
    logic [LEN_W-1:0] pad_words = '0;
    logic [W-1:0]     in_bits = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     out_bits;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_last;
    logic             burst_done;
    logic             start_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    derand_burst #(.W(W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .burst_start (burst_start),
        .rand_iv     (rand_iv),
        .data_words  (data_words),
        .pad_words   (pad_words),
        .in_bits     (in_bits),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_bits    (out_bits),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .burst_done  (burst_done),
        .start_err   (start_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Keystream as a bit sequence: the seed supplies the 15 bits preceding
    // time 0 (seed bit k is the bit at time -1-k), then s[n] = s[n-14]^s[n-15].
    logic ks_seq [0:15+W*MAXW-1];
    int   m_d;
    int   m_idx;

    typedef struct {
        logic [W-1:0] bits;
        logic         last;
    } exp_t;
    exp_t exp_q[$];

    task automatic new_burst(input logic [14:0] iv, input int d);
        for (int j = 0; j < 15; j++) ks_seq[j] = iv[14-j];
        for (int n = 0; n < W*MAXW; n++) ks_seq[15+n] = ks_seq[n+1] ^ ks_seq[n];
        m_d   = d;
        m_idx = 0;
    endtask

    function automatic logic [W-1:0] ks_word(input int k);
        logic [W-1:0] r;
        for (int b = 0; b < W; b++) r[b] = ks_seq[15 + k*W + b];
        return r;
    endfunction

    task automatic model_accept(input logic [W-1:0] w);
        exp_t e;
        if (m_idx < m_d) begin
            e.bits = w ^ ks_word(m_idx);
            e.last = (m_idx == m_d - 1);
            exp_q.push_back(e);
        end
        m_idx++;
    endtask

    // Output monitor: every handshake is scored, stalled words must hold.
    logic [W-1:0] seen[$];
    logic         seen_last[$];
    logic         held_v = 1'b0;
    logic [W-1:0] held_bits = '0;
    logic         held_last = 1'b0;
    int           out_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (reset) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_bits", 32'(out_bits), 32'(held_bits));
                chk("hold_last", 32'(out_last), 32'(held_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    chk("out_bits", 32'(out_bits), 32'(e.bits));
                    chk("out_last", 32'(out_last), 32'(e.last));
                end
                seen.push_back(out_bits);
                seen_last.push_back(out_last);
                out_cnt++;
            end
            held_v    = out_valid && !out_ready;
            held_bits = out_bits;
            held_last = out_last;
        end
    end

    task automatic start_burst(input logic [14:0] iv, input int d, input int p);
        burst_start = 1'b1;
        rand_iv     = iv;
        data_words  = LEN_W'(d);
        pad_words   = LEN_W'(p);
        @(posedge clk);
        new_burst(iv, d);
        @(negedge clk);
        burst_start = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_bits  = w;
        #1;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 100) begin
                fail_now("accept_timeout");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_accept(w);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || out_valid) begin
            @(negedge clk);
            #3;
            n++;
            if (n > 100) begin
                fail_now("drain_timeout");
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic keystream_burst(input string tag);
        int s0;
        s0 = seen.size();
        start_burst(15'h0001, 2, 0);
        send_word(8'h00);
        send_word(8'h00);
        chk({tag, "_done"}, 32'(burst_done), 32'd1);
        wait_drain();
        if (seen.size() >= s0 + 2) begin
            chk({tag, "_w0"}, 32'(seen[s0]), 32'h00);
            chk({tag, "_w1"}, 32'(seen[s0+1]), 32'h60);
            chk({tag, "_last0"}, 32'(seen_last[s0]), 32'd0);
            chk({tag, "_last1"}, 32'(seen_last[s0+1]), 32'd1);
        end else begin
            fail_now({tag, "_missing_words"});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] payload [0:63];
        logic [W-1:0] wl [0:5];
        int s0;
        int errs;
        int lasts;

        // Reset state while reset is held
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bits", 32'(out_bits), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_burst_done", 32'(burst_done), 32'd0);
        chk("rst_start_err", 32'(start_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Pin the model against hand-derived keystream for seed 1
        new_burst(15'h0001, 2);
        chk("model_ks0", 32'(ks_word(0)), 32'h00);
        chk("model_ks1", 32'(ks_word(1)), 32'h60);
        new_burst(15'h0000, 2);
        chk("model_ks_seed0", 32'(ks_word(1)), 32'h00);

        keystream_burst("ks");
        chk("ks_done_pulse", 32'(burst_done), 32'd0);

        // Round trip: bench scrambles with the same seed, DUT must restore it
        for (int i = 0; i < 64; i++) payload[i] = W'($urandom);
        s0 = seen.size();
        start_burst(15'h6E15, 64, 0);
        for (int i = 0; i < 64; i++) send_word(payload[i] ^ ks_word(i));
        chk("rt_done", 32'(burst_done), 32'd1);
        wait_drain();
        errs = 0;
        lasts = 0;
        for (int i = 0; i < 64; i++) begin
            if (s0 + i >= seen.size() || seen[s0+i] !== payload[i]) errs++;
            else if (seen_last[s0+i] !== (i == 63)) errs++;
            else if (seen_last[s0+i]) lasts++;
        end
        chk("rt_payload_errs", 32'(errs), 32'd0);
        chk("rt_last_count", 32'(lasts), 32'd1);

        // Padding: 3 data + 4 pad words, only 3 outputs
        s0 = out_cnt;
        start_burst(15'h1234, 3, 4);
        for (int i = 0; i < 7; i++) begin
            if (i >= 3) begin
                #1;
                chk("pad_in_ready", 32'(in_ready), 32'd1);
                if (i < 6) chk("pad_not_done", 32'(burst_done), 32'd0);
            end
            send_word(W'(8'h11 * (i + 1)));
        end
        chk("pad_done", 32'(burst_done), 32'd1);
        wait_drain();
        chk("pad_out_count", 32'(out_cnt - s0), 32'd3);

        // Backpressure: sink stalls five cycles mid-burst
        wl[0] = 8'hA5; wl[1] = 8'h3C; wl[2] = 8'hFF;
        wl[3] = 8'h00; wl[4] = 8'h81; wl[5] = 8'h7E;
        s0 = out_cnt;
        start_burst(15'h5A5A, 6, 0);
        send_word(wl[0]);
        send_word(wl[1]);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bits   = wl[2];
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 2; i < 6; i++) send_word(wl[i]);
        chk("bp_done", 32'(burst_done), 32'd1);
        wait_drain();
        chk("bp_out_count", 32'(out_cnt - s0), 32'd6);

        // Empty burst, and in_valid while idle is ignored
        s0 = out_cnt;
        start_burst(15'h0ABC, 0, 0);
        chk("empty_done", 32'(burst_done), 32'd1);
        in_valid = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("empty_done_pulse", 32'(burst_done), 32'd0);
        chk("empty_no_err", 32'(start_err), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("empty_out_count", 32'(out_cnt - s0), 32'd0);

        // burst_start during DATA: error pulse, burst continues unchanged
        s0 = out_cnt;
        start_burst(15'h0F0F, 4, 0);
        send_word(8'h12);
        send_word(8'h34);
        burst_start = 1'b1;
        rand_iv     = 15'h7FFF;
        data_words  = LEN_W'(1);
        pad_words   = '0;
        #1;
        chk("err_before", 32'(start_err), 32'd0);
        @(negedge clk);
        burst_start = 1'b0;
        chk("err_pulse", 32'(start_err), 32'd1);
        @(negedge clk);
        chk("err_clear", 32'(start_err), 32'd0);
        send_word(8'h56);
        chk("err_not_done", 32'(burst_done), 32'd0);
        send_word(8'h78);
        chk("err_done", 32'(burst_done), 32'd1);
        wait_drain();
        chk("err_out_count", 32'(out_cnt - s0), 32'd4);

        // New burst_start in the burst_done cycle
        s0 = out_cnt;
        start_burst(15'h2222, 1, 0);
        send_word(8'hC3);
        chk("b2b_done_a", 32'(burst_done), 32'd1);
        start_burst(15'h3333, 2, 1);
        chk("b2b_no_err", 32'(start_err), 32'd0);
        send_word(8'h01);
        send_word(8'h02);
        send_word(8'h03);
        chk("b2b_done_b", 32'(burst_done), 32'd1);
        wait_drain();
        chk("b2b_out_count", 32'(out_cnt - s0), 32'd3);

        // Reset mid-DATA with a held output word
        start_burst(15'h4444, 5, 0);
        send_word(8'h9A);
        send_word(8'hBC);
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_bits", 32'(out_bits), 32'd0);
        chk("mid_rst_out_last", 32'(out_last), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_done", 32'(burst_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        keystream_burst("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
